// File: rtl/data_transmitter_pkg.sv
// Shared types and defaults for the serial/parallel link converter.
package data_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SIPO_SHIFT,
    PISO_SHIFT
  } xfer_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/xfer_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear and enable.
// last_o flags the final bit position of a transfer.
module xfer_bit_counter
  import data_transmitter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_transmitter.sv
// Bidirectional serial/parallel converter: one start pulse runs one
// WIDTH-bit SIPO or PISO transfer through a shared left-shifting register.
module data_transmitter
  import data_transmitter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_select,
  input  logic             start,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out
);

  xfer_state_t      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             serial_out_q;
  logic [WIDTH-1:0] parallel_out_q;
  logic             last_bit;

  // Counter sits at zero while idle, so an accepted start begins at bit 0.
  xfer_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .en_i  (state_q != IDLE),
    .last_o(last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      serial_out_q   <= 1'b0;
      parallel_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (mode_select) begin
              state_q <= SIPO_SHIFT;
            end else begin
              state_q      <= PISO_SHIFT;
              shreg_q      <= parallel_in;
              serial_out_q <= parallel_in[WIDTH-1];
            end
          end
        end
        SIPO_SHIFT: begin
          shreg_q <= {shreg_q[WIDTH-2:0], serial_in};
          if (last_bit) begin
            parallel_out_q <= {shreg_q[WIDTH-2:0], serial_in};
            state_q        <= IDLE;
          end
        end
        PISO_SHIFT: begin
          // MSB already presented at the start edge; each edge exposes the next bit.
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          if (last_bit) begin
            serial_out_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            serial_out_q <= shreg_q[WIDTH-2];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_out   = serial_out_q;
  assign parallel_out = parallel_out_q;

endmodule

// File: tb/tb_data_transmitter.sv
// Directed and randomized bench for data_transmitter with a word-level
// reference model of the SIPO/PISO transfers.
module tb_data_transmitter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode_select;
  logic         start;
  logic         serial_in;
  logic [W-1:0] parallel_in;
  logic         serial_out;
  logic [W-1:0] parallel_out;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_pout;

  always #5 clk = ~clk;

  data_transmitter #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_select (mode_select),
    .start       (start),
    .serial_in   (serial_in),
    .parallel_in (parallel_in),
    .serial_out  (serial_out),
    .parallel_out(parallel_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      check("idle_sout", W'(serial_out), W'(0));
      check("idle_pout", parallel_out, exp_pout);
    end
  endtask

  // SIPO of 'word'. poke re-pulses start with PISO mode mid-transfer;
  // abort_at >= 0 asserts reset after that many bits have been shifted.
  task automatic run_sipo(input logic [W-1:0] word, input bit poke, input int abort_at);
    logic [W-1:0] acc;
    logic         b;
    acc         = '0;
    mode_select = 1'b1;
    start       = 1'b1;
    step();
    start       = 1'b0;
    mode_select = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        rst      = 1'b0;
        exp_pout = '0;
        check("abort_pout", parallel_out, exp_pout);
        check("abort_sout", W'(serial_out), W'(0));
        return;
      end
      b         = (word >> (W - 1 - i)) & 1;
      serial_in = b;
      acc       = (acc << 1) | W'(b);
      if (poke && i == 3) begin
        start       = 1'b1;
        mode_select = 1'b0;
        parallel_in = '1;
      end
      step();
      start     = 1'b0;
      serial_in = 1'($urandom);
      if (i < W - 1) check("sipo_hold", parallel_out, exp_pout);
      check("sipo_sout", W'(serial_out), W'(0));
    end
    exp_pout = acc;
    check("sipo_word", parallel_out, exp_pout);
  endtask

  task automatic run_piso(input logic [W-1:0] word);
    mode_select = 1'b0;
    parallel_in = word;
    start       = 1'b1;
    step();
    start       = 1'b0;
    parallel_in = W'($urandom);
    mode_select = 1'($urandom);
    for (int j = 0; j < W; j++) begin
      check("piso_bit", W'(serial_out), (word >> (W - 1 - j)) & 1);
      check("piso_pout", parallel_out, exp_pout);
      serial_in = 1'($urandom);
      step();
    end
    check("piso_end", W'(serial_out), W'(0));
  endtask

  initial begin
    logic [W-1:0] w;
    rst         = 1'b1;
    start       = 1'b0;
    mode_select = 1'b0;
    serial_in   = 1'b0;
    parallel_in = '0;
    exp_pout    = '0;
    step();
    step();
    check("reset_pout", parallel_out, 8'h00);
    check("reset_sout", W'(serial_out), W'(0));
    rst = 1'b0;

    run_sipo(8'b10110101, 1'b0, -1);
    check("sipo_B5", parallel_out, 8'hB5);
    idle_cycles(2);

    run_piso(8'b11001100);
    idle_cycles(1);

    run_sipo(8'h3C, 1'b1, -1);
    idle_cycles(W + 2);

    run_sipo(8'hFF, 1'b0, 4);
    check("abort_zero", parallel_out, 8'h00);
    run_sipo(8'hA5, 1'b0, -1);
    check("sipo_A5", parallel_out, 8'hA5);

    run_piso(8'h81);
    run_sipo(W'($urandom), 1'b0, -1);
    idle_cycles(1);

    for (int r = 0; r < 10; r++) begin
      w = W'($urandom);
      if ($urandom_range(0, 1) == 1) run_sipo(w, 1'($urandom), -1);
      else run_piso(w);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
